contrast_map_ctrl: RTL and testbench
====================================

CONTRAST_MAP_CTRL -- requirements
Module: contrast_map_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  pixel clock; all state changes on its rising edge
  rst_n  in  1  asynchronous active-low reset
  s_valid  in  1  input sample valid
  s_ready  out  1  input sample accepted when s_valid&s_ready
  s_data  in  7  input luminance sample, 0x00..0x7F
  s_sof  in  1  first sample of frame
  s_eol  in  1  last sample of line
  curve_sel  in  4  requested contrast curve, 0 = identity
  rom_ad  out  11  to cos_table ad = {curve[3:0], sample[6:0]}
  rom_ce  out  1  to cos_table ce
  rom_oce  out  1  to cos_table oce, constant 1
  rom_reset  out  1  to cos_table reset, constant 0
  rom_dout  in  8  from cos_table dout, valid 1 cycle after a rom_ce cycle
  m_valid  out  1  output sample valid
  m_ready  in  1  downstream ready
  m_data  out  8  mapped sample
  m_sof  out  1  s_sof carried with the sample
  m_eol  out  1  s_eol carried with the sample
  cur_curve  out  4  curve in force for the current frame

Function
REQ-003 Accept: a beat SHALL be accepted in a cycle where s_valid=1 and s_ready=1; in that cycle rom_ce=1, otherwise rom_ce=0.
REQ-004 Address: rom_ad SHALL be combinational {curve_sel, s_data} when s_sof=1, else {cur_curve, s_data}.
REQ-005 Curve latch: on an accepted beat with s_sof=1, cur_curve SHALL load curve_sel; curve_sel changes mid-frame SHALL have no effect until the next s_sof beat.
REQ-006 In-flight flag r1_valid SHALL be 1 in the cycle after an accept, and the same cycle's rom_dout, sof and eol SHALL be written into a 3-entry output FIFO at the end of that cycle.
REQ-007 Latency SHALL be exactly 2 cycles from accept to m_valid when the FIFO is empty; m_data/m_sof/m_eol SHALL come from the FIFO head.
REQ-008 s_ready SHALL be 1 iff (FIFO occupancy + r1_valid) <= 2, using occupancy before this cycle's pop; the FIFO SHALL never overflow.
REQ-009 Throughput SHALL be 1 sample/cycle while m_ready=1 continuously.
REQ-010 m_data/m_sof/m_eol SHALL hold stable while m_valid=1 and m_ready=0.
REQ-011 On a simultaneous push and pop, occupancy SHALL stay unchanged and order SHALL be preserved; a pop when empty SHALL be ignored.
REQ-012 Sample order and the sof/eol association SHALL be preserved end to end; no beat is dropped or duplicated.

Reset
REQ-013 When rst_n=0: m_valid=0, s_ready=0, rom_ce=0, r1_valid=0, FIFO empty, cur_curve=0, m_data/m_sof/m_eol=0.
REQ-014 A reset asserted mid-stream SHALL discard in-flight and buffered beats; s_ready SHALL go to 1 on the first clock edge after rst_n deasserts.

Structure
REQ-015 Package contrast_map_pkg SHALL hold SAMPLE_W=7, CURVE_W=4, OUT_W=8, ROM_AW=11, FIFO_DEPTH=3, CURVE_IDENTITY=0.
REQ-016 The output FIFO SHALL be the sub-module contrast_skid_fifo; cos_table is instantiated by the parent, not inside this block.

Verification
REQ-017 After reset with curve 0: send s_data=0x05 (sof=1) -> m_data=0x05, m_sof=1, 2 cycles after accept.
REQ-018 With curve_sel=15 on a sof beat, send samples 0x10, 0x73, 0x7F -> m_data 0x00, 0x05, 0x7F; cur_curve=15.
REQ-019 Change curve_sel from 1 to 15 mid-frame, then send 0x02 -> m_data=0x01 (curve 1 is still in force); the next sof beat switches to curve 15.
REQ-020 Stream 64 samples with m_ready=1 -> 64 outputs on consecutive cycles, no s_ready gaps after the first accept.
REQ-021 Hold m_ready=0 during a burst -> s_ready drops after 3 outstanding beats, m_data stays stable, and all beats appear in order after release.
REQ-022 Pulse rst_n low with 2 beats in flight -> m_valid=0 immediately, the stale beats never appear, cur_curve=0.

Source files
------------

// File: rtl/contrast_map_pkg.sv
// rtl/contrast_map_pkg.sv - shared widths, output beat type and ROM address helper
package contrast_map_pkg;

    localparam int SAMPLE_W   = 7;
    localparam int CURVE_W    = 4;
    localparam int OUT_W      = 8;
    localparam int ROM_AW     = 11;
    localparam int FIFO_DEPTH = 3;

    localparam logic [CURVE_W-1:0] CURVE_IDENTITY = 4'd0;

    // One mapped sample with its framing markers, as stored in the output FIFO
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sof;
        logic             eol;
    } out_beat_t;

    localparam int BEAT_W = $bits(out_beat_t);

    // The curve selects a 128-entry page of the table; the sample indexes within it
    function automatic logic [ROM_AW-1:0] rom_addr(input logic [CURVE_W-1:0]  curve,
                                                   input logic [SAMPLE_W-1:0] sample);
        return {curve, sample};
    endfunction

endpackage

// File: rtl/contrast_skid_fifo.sv
// rtl/contrast_skid_fifo.sv - small circular FIFO holding mapped beats for the output port
module contrast_skid_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 3,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_tvalid,
    input  logic [W-1:0]  s_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [W-1:0]  m_tdata,
    output logic [CW-1:0] level
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // A pop on an empty FIFO is ignored; a push into a full one only lands if a pop frees a slot
    assign pop      = m_tready && (level != '0);
    assign push     = s_tvalid && ((level != FULL) || pop);
    assign m_tvalid = (level != '0);
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

    // Storage, pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/contrast_map_ctrl.sv
// rtl/contrast_map_ctrl.sv - maps luminance samples through an external contrast table
module contrast_map_ctrl
    import contrast_map_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_sof,
    input  logic                s_eol,
    input  logic [CURVE_W-1:0]  curve_sel,
    output logic [ROM_AW-1:0]   rom_ad,
    output logic                rom_ce,
    output logic                rom_oce,
    output logic                rom_reset,
    input  logic [OUT_W-1:0]    rom_dout,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [OUT_W-1:0]    m_data,
    output logic                m_sof,
    output logic                m_eol,
    output logic [CURVE_W-1:0]  cur_curve
);

    logic       run;
    logic       r1_valid;
    logic       r1_sof;
    logic       r1_eol;
    logic       accept;
    logic [1:0] fifo_level;
    out_beat_t  push_beat;
    out_beat_t  head_beat;

    // Admit a sample only if it is guaranteed a FIFO slot once its table read returns
    assign s_ready   = run && (({1'b0, fifo_level} + {2'b00, r1_valid}) <= 3'd2);
    assign accept    = s_valid && s_ready;
    assign rom_ce    = accept;
    assign rom_oce   = 1'b1;
    assign rom_reset = 1'b0;

    // A start-of-frame beat already uses the newly requested curve
    assign rom_ad = rom_addr(s_sof ? curve_sel : cur_curve, s_data);

    // Track the table read in flight, its framing markers and the per-frame curve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            r1_valid  <= 1'b0;
            r1_sof    <= 1'b0;
            r1_eol    <= 1'b0;
            cur_curve <= CURVE_IDENTITY;
        end else begin
            run      <= 1'b1;
            r1_valid <= accept;
            if (accept) begin
                r1_sof <= s_sof;
                r1_eol <= s_eol;
                if (s_sof) begin
                    cur_curve <= curve_sel;
                end
            end
        end
    end

    assign push_beat.data = rom_dout;
    assign push_beat.sof  = r1_sof;
    assign push_beat.eol  = r1_eol;

    contrast_skid_fifo #(
        .W     (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (r1_valid),
        .s_tdata  (push_beat),
        .m_tvalid (m_valid),
        .m_tready (m_ready),
        .m_tdata  (head_beat),
        .level    (fifo_level)
    );

    assign m_data = head_beat.data;
    assign m_sof  = head_beat.sof;
    assign m_eol  = head_beat.eol;

endmodule

// File: tb/tb_contrast_map_ctrl.sv
// tb/tb_contrast_map_ctrl.sv - self-checking bench for contrast_map_ctrl
module tb_contrast_map_ctrl;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [6:0]  s_data;
    logic        s_sof;
    logic        s_eol;
    logic [3:0]  curve_sel;
    logic [10:0] rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [7:0]  rom_dout;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_sof;
    logic        m_eol;
    logic [3:0]  cur_curve;

    contrast_map_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .s_eol     (s_eol),
        .curve_sel (curve_sel),
        .rom_ad    (rom_ad),
        .rom_ce    (rom_ce),
        .rom_oce   (rom_oce),
        .rom_reset (rom_reset),
        .rom_dout  (rom_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sof     (m_sof),
        .m_eol     (m_eol),
        .cur_curve (cur_curve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Table model: synchronous read, data valid the cycle after a ce cycle
    logic [7:0] rom_mem [2048];
    logic [7:0] rom_q = 8'h00;
    always @(posedge clk) if (rom_ce) rom_q <= rom_mem[rom_ad];
    assign rom_dout = rom_q;

    // Reference: every accepted beat is queued with its mapped value; outputs pop in order
    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eol;
    } exp_t;
    exp_t       exp_q[$];
    logic [3:0] mdl_curve = 4'd0;
    logic       arm;
    logic       hold_prev = 1'b0;
    logic [9:0] hold_val  = '0;
    int         pop_cnt   = 0;
    int         pop_first = -1;
    int         pop_last  = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) arm <= 1'b0;
        else        arm <= 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mdl_curve = 4'd0;
            hold_prev = 1'b0;
        end else begin
            logic [3:0] c;
            exp_t       e;
            chk("s_ready_rule", {31'd0, s_ready}, {31'd0, arm && (exp_q.size() <= 2)});
            chk("rom_ce_rule", {31'd0, rom_ce}, {31'd0, s_valid && s_ready});
            c = s_sof ? curve_sel : mdl_curve;
            if (s_valid) chk("rom_ad", {21'd0, rom_ad}, {21'd0, c, s_data});
            if (hold_prev) chk("hold_stable", {21'd0, m_valid, m_data, m_sof, m_eol}, {21'd0, 1'b1, hold_val});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {31'd0, m_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", {24'd0, m_data}, {24'd0, e.d});
                    chk("m_sof", {31'd0, m_sof}, {31'd0, e.sof});
                    chk("m_eol", {31'd0, m_eol}, {31'd0, e.eol});
                end
                if (pop_first < 0) pop_first = cyc;
                pop_last = cyc;
                pop_cnt++;
            end
            hold_prev = m_valid && !m_ready;
            hold_val  = {m_data, m_sof, m_eol};
            if (s_valid && s_ready) begin
                if (s_sof) mdl_curve = curve_sel;
                exp_q.push_back('{rom_mem[{c, s_data}], s_sof, s_eol});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns just after the accepting edge
    task automatic send_beat(input logic [6:0] d, input logic sof, input logic eol, input logic [3:0] cs);
        int waited;
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol; curve_sel = cs;
        waited = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", {31'd0, s_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    typedef struct {
        logic [6:0] d;
        logic       sof;
        logic       eol;
        logic [3:0] cs;
        logic [7:0] exp_d;
        logic [3:0] exp_cur;
    } vec_t;
    vec_t vt[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        int gaps;
        int iter;
        int i;

        for (int a = 0; a < 2048; a++) rom_mem[a] = 8'($urandom);
        for (int s = 0; s < 128; s++) begin
            rom_mem[{4'd0, 7'(s)}] = 8'(s);
            rom_mem[{4'd1, 7'(s)}] = 8'(s >> 1);
        end
        rom_mem[{4'd15, 7'h10}] = 8'h00;
        rom_mem[{4'd15, 7'h73}] = 8'h05;
        rom_mem[{4'd15, 7'h7F}] = 8'h7F;
        rom_mem[{4'd15, 7'h02}] = 8'hA5;

        vt[0] = '{7'h05, 1'b1, 1'b0, 4'd0,  8'h05, 4'd0};
        vt[1] = '{7'h10, 1'b1, 1'b0, 4'd15, 8'h00, 4'd15};
        vt[2] = '{7'h73, 1'b0, 1'b0, 4'd15, 8'h05, 4'd15};
        vt[3] = '{7'h7F, 1'b0, 1'b1, 4'd15, 8'h7F, 4'd15};
        vt[4] = '{7'h40, 1'b1, 1'b0, 4'd1,  8'h20, 4'd1};
        vt[5] = '{7'h02, 1'b0, 1'b1, 4'd15, 8'h01, 4'd1};
        vt[6] = '{7'h02, 1'b1, 1'b0, 4'd15, 8'hA5, 4'd15};

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eol = 1'b0;
        curve_sel = 4'd0; m_ready = 1'b1;
        step(3);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
        chk("rst_cur_curve", {28'd0, cur_curve}, 32'd0);
        chk("rst_m_out", {22'd0, m_data, m_sof, m_eol}, 32'd0);
        chk("rom_oce", {31'd0, rom_oce}, 32'd1);
        chk("rom_reset", {31'd0, rom_reset}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_edge", {31'd0, s_ready}, 32'd1);
        step(1);

        // Directed vectors: exact latency, mapping and curve latching
        for (int k = 0; k < 7; k++) begin
            send_beat(vt[k].d, vt[k].sof, vt[k].eol, vt[k].cs);
            @(negedge clk);
            chk($sformatf("vec%0d_cur_curve", k), {28'd0, cur_curve}, {28'd0, vt[k].exp_cur});
            chk($sformatf("vec%0d_lat1_idle", k), {31'd0, m_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_lat2_valid", k), {31'd0, m_valid}, 32'd1);
            chk($sformatf("vec%0d_data", k), {24'd0, m_data}, {24'd0, vt[k].exp_d});
            chk($sformatf("vec%0d_sof", k), {31'd0, m_sof}, {31'd0, vt[k].sof});
            step(2);
        end

        // Continuous stream at full rate
        m_ready = 1'b1; pop_cnt = 0; pop_first = -1; pop_last = -1;
        gaps = 0; i = 0; iter = 0;
        while (i < 64 && iter < 200) begin
            s_valid = 1'b1; s_data = 7'($urandom); s_sof = (i == 0); s_eol = (i % 16 == 15);
            curve_sel = 4'd3;
            @(negedge clk);
            if (s_ready) i++;
            else if (i > 0) gaps++;
            @(posedge clk); #1;
            iter++;
        end
        s_valid = 1'b0;
        step(6);
        chk("stream_outputs", pop_cnt, 64);
        chk("stream_consecutive", pop_last - pop_first, 63);
        chk("stream_ready_gaps", gaps, 0);

        // Backpressure burst: only three beats may be outstanding
        m_ready = 1'b0; accepts = 0;
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1; s_data = 7'($urandom); s_sof = (k == 0); s_eol = 1'b0; curve_sel = 4'd9;
            @(negedge clk);
            if (s_ready) accepts++;
            @(posedge clk); #1;
        end
        chk("bp_accepts", accepts, 3);
        chk("bp_ready_low", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        step(3);
        m_ready = 1'b1;
        step(8);
        chk("bp_drained", exp_q.size(), 0);

        // Mid-stream reset with beats in flight
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 7'h11; s_sof = 1'b1; curve_sel = 4'd7;
        @(posedge clk); #1;
        s_data = 7'h12; s_sof = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("mid_rst_cur_curve", {28'd0, cur_curve}, 32'd0);
        step(2);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_ready", {31'd0, s_ready}, 32'd1);
        pop_cnt = 0;
        step(6);
        chk("no_stale_beats", pop_cnt, 0);
        send_beat(7'h33, 1'b1, 1'b0, 4'd0);
        step(4);
        chk("post_rst_beat", pop_cnt, 1);

        // Randomized traffic against the queue model
        for (int k = 0; k < 3000; k++) begin
            s_valid   = ($urandom % 4) != 0;
            s_data    = 7'($urandom);
            s_sof     = ($urandom % 8) == 0;
            s_eol     = ($urandom % 6) == 0;
            curve_sel = 4'($urandom);
            m_ready   = ($urandom % 3) != 0;
            step(1);
        end
        s_valid = 1'b0; m_ready = 1'b1;
        step(10);
        chk("random_drained", exp_q.size(), 0);
        chk("random_idle_valid", {31'd0, m_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
